// File: rtl/joypad_autopoll.sv
// joypad_autopoll: autonomous poll sequencer for the two serial joypad ports.
// On a poll request it latches both pads, clocks in 8 bits from each and
// publishes them to two shadow registers. The CPU's $4016/$4017 path always wins:
// any CPU access aborts the poll, and the poll restarts once the CPU is done.
//
// Ports:
//   clk, rst            - system clock; synchronous active-high reset
//   poll_req            - single-cycle poll request
//   cpu_access          - CPU is addressing $4016/$4017
//   controller_data1/2  - pad serial data, active-low
//   pad_latch           - latch drive (meaningful only while own=1)
//   pad1_clk, pad2_clk  - pad clocks, idle high
//   own                 - this block owns the pad lines (top-level mux select)
//   pad1/2_buttons      - shadow registers, bit i = i-th bit read, 1 = pressed
//   buttons_valid       - one-cycle pulse when the shadows update
//   busy                - poll active or pending
//
// Build option: define JOYPAD_AUTOPOLL_DEBOUNCE_EN to update a shadow only when
// two consecutive completed polls agree, and pulse buttons_valid only on change.
module joypad_autopoll #(
  parameter int unsigned LATCH_CYCLES = 12,
  parameter int unsigned HALF_PERIOD  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       cpu_access,
  input  logic       controller_data1,
  input  logic       controller_data2,
  output logic       pad_latch,
  output logic       pad1_clk,
  output logic       pad2_clk,
  output logic       own,
  output logic [7:0] pad1_buttons,
  output logic [7:0] pad2_buttons,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int unsigned MaxCycles = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] LatchLoad = CntW'(LATCH_CYCLES - 1);
  localparam logic [CntW-1:0] HalfLoad  = CntW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLatch   = 3'd1,
    StGap     = 3'd2,
    StClkLow  = 3'd3,
    StClkHigh = 3'd4,
    StDone    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      work1_q, work1_d, work2_q, work2_d;
  logic [7:0]      shad1_q, shad1_d, shad2_q, shad2_d;
  logic            pending_q, pending_d;
  logic            latch_q, latch_d;
  logic            pclk_q, pclk_d;
  logic            own_q, own_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            last;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
  logic [7:0]      prev1_q, prev1_d, prev2_q, prev2_d;
`endif

  assign last = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    work1_d   = work1_q;
    work2_d   = work2_q;
    shad1_d   = shad1_q;
    shad2_d   = shad2_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
`endif

    unique case (state_q)
      StIdle: begin
        if ((poll_req || pending_q) && !cpu_access) begin
          state_d   = StLatch;
          cnt_d     = LatchLoad;
          bit_cnt_d = 3'd0;
          pending_d = 1'b0;
        end else if (poll_req && cpu_access) begin
          pending_d = 1'b1;
        end
      end
      StLatch: begin
        if (last) begin
          state_d = StGap;
          cnt_d   = HalfLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (last) begin
          // Bit 0 is already on the data line once the latch drops.
          work1_d[0] = ~controller_data1;
          work2_d[0] = ~controller_data2;
          bit_cnt_d  = 3'd1;
          state_d    = StClkLow;
          cnt_d      = HalfLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StClkLow: begin
        if (last) begin
          state_d = StClkHigh;
          cnt_d   = HalfLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StClkHigh: begin
        if (last) begin
          work1_d[bit_cnt_q] = ~controller_data1;
          work2_d[bit_cnt_q] = ~controller_data2;
          if (bit_cnt_q == 3'd7) begin
            // Commit on entry to DONE so the shadows and the pulse appear together.
            state_d = StDone;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
            prev1_d = work1_d;
            prev2_d = work2_d;
            if (work1_d == prev1_q) shad1_d = work1_d;
            if (work2_d == prev2_q) shad2_d = work2_d;
            valid_d = (shad1_d != shad1_q) || (shad2_d != shad2_q);
`else
            shad1_d = work1_d;
            shad2_d = work2_d;
            valid_d = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = StClkLow;
            cnt_d     = HalfLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        if (poll_req && cpu_access) pending_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // CPU access aborts an active poll; a commit computed this cycle is dropped.
    if (cpu_access && (state_q != StIdle) && (state_q != StDone)) begin
      state_d   = StIdle;
      pending_d = 1'b1;
      shad1_d   = shad1_q;
      shad2_d   = shad2_q;
      valid_d   = 1'b0;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
      prev1_d   = prev1_q;
      prev2_d   = prev2_q;
`endif
    end

    own_d   = (state_d != StIdle);
    latch_d = (state_d == StLatch);
    pclk_d  = (state_d != StClkLow);
    busy_d  = own_d | pending_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      work1_q   <= 8'h00;
      work2_q   <= 8'h00;
      shad1_q   <= 8'h00;
      shad2_q   <= 8'h00;
      pending_q <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      own_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
      prev1_q   <= 8'h00;
      prev2_q   <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      work1_q   <= work1_d;
      work2_q   <= work2_d;
      shad1_q   <= shad1_d;
      shad2_q   <= shad2_d;
      pending_q <= pending_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
      own_q     <= own_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
`endif
    end
  end

  assign pad_latch     = latch_q;
  assign pad1_clk      = pclk_q;
  assign pad2_clk      = pclk_q;
  assign own           = own_q;
  assign pad1_buttons  = shad1_q;
  assign pad2_buttons  = shad2_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_joypad_autopoll.sv
// Bench for joypad_autopoll: pad models, a scoreboard of expected shadow
// updates checked whenever buttons_valid pulses, and a line-timing monitor.
module tb_joypad_autopoll;
  localparam int unsigned L = 12;
  localparam int unsigned H = 6;

  logic       clk = 1'b0;
  logic       rst, poll_req, cpu_access;
  logic       controller_data1, controller_data2;
  logic       pad_latch, pad1_clk, pad2_clk, own, buttons_valid, busy;
  logic [7:0] pad1_buttons, pad2_buttons;

  joypad_autopoll #(.LATCH_CYCLES(L), .HALF_PERIOD(H)) dut (
    .clk              (clk),
    .rst              (rst),
    .poll_req         (poll_req),
    .cpu_access       (cpu_access),
    .controller_data1 (controller_data1),
    .controller_data2 (controller_data2),
    .pad_latch        (pad_latch),
    .pad1_clk         (pad1_clk),
    .pad2_clk         (pad2_clk),
    .own              (own),
    .pad1_buttons     (pad1_buttons),
    .pad2_buttons     (pad2_buttons),
    .buttons_valid    (buttons_valid),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad models: active-low patterns, bit 0 presented first, shift on rising clock.
  logic [7:0] pat1 = 8'hFF, pat2 = 8'hFF;
  logic [3:0] idx1 = 4'd0, idx2 = 4'd0;
  logic       pc1_prev = 1'b1, pc2_prev = 1'b1;
  assign controller_data1 = (idx1 < 4'd8) ? pat1[idx1[2:0]] : 1'b1;
  assign controller_data2 = (idx2 < 4'd8) ? pat2[idx2[2:0]] : 1'b1;

  initial forever begin
    @(negedge clk);
    if (own === 1'b1 && pad_latch === 1'b1) begin
      idx1 = 4'd0;
      idx2 = 4'd0;
    end else begin
      if (own === 1'b1 && pad1_clk === 1'b1 && pc1_prev === 1'b0 && idx1 < 4'd8) idx1 = idx1 + 4'd1;
      if (own === 1'b1 && pad2_clk === 1'b1 && pc2_prev === 1'b0 && idx2 < 4'd8) idx2 = idx2 + 4'd1;
    end
    pc1_prev = pad1_clk;
    pc2_prev = pad2_clk;
  end

  // Scoreboard
  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    int         vcyc;
  } exp_t;
  exp_t sb[$];

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst === 1'b0 && buttons_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got a pulse at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.vcyc);
        chk("pad1_buttons", {24'd0, pad1_buttons}, {24'd0, e.p1});
        chk("pad2_buttons", {24'd0, pad2_buttons}, {24'd0, e.p2});
      end
    end
  end

  // Reference model of the shadow/debounce behaviour
  logic [7:0] m_sh1 = 8'h00, m_sh2 = 8'h00, m_prev1 = 8'h00, m_prev2 = 8'h00;

  task automatic expect_done(input logic [7:0] n1, input logic [7:0] n2, input int vcyc);
    logic [7:0] s1, s2;
    logic       chg;
`ifdef JOYPAD_AUTOPOLL_DEBOUNCE_EN
    s1 = m_sh1;
    s2 = m_sh2;
    if (n1 == m_prev1) s1 = n1;
    if (n2 == m_prev2) s2 = n2;
    m_prev1 = n1;
    m_prev2 = n2;
    chg = (s1 != m_sh1) || (s2 != m_sh2);
`else
    s1  = n1;
    s2  = n2;
    chg = 1'b1;
`endif
    m_sh1 = s1;
    m_sh2 = s2;
    if (chg) sb.push_back('{p1: s1, p2: s2, vcyc: vcyc});
  endtask

  // Line timing monitor
  int   latch_run = 0, last_latch_len = 0, low_run = 0, low_cnt = 0, width_bad = 0;
  int   line_viol = 0, own_rise_cyc = 0, own_fall_cyc = 0;
  logic own_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b0 || cyc < 2) begin
      latch_run = 0;
      low_run   = 0;
      own_prev  = 1'b0;
    end else begin
      if (pad_latch === 1'b1) begin
        if (latch_run == 0) begin
          low_cnt   = 0;
          width_bad = 0;
        end
        latch_run++;
      end else if (latch_run != 0) begin
        last_latch_len = latch_run;
        latch_run      = 0;
      end
      if (pad1_clk === 1'b0) low_run++;
      else if (low_run != 0) begin
        low_cnt++;
        if (low_run != H) width_bad++;
        low_run = 0;
      end
      if (pad1_clk !== pad2_clk) line_viol++;
      if (own === 1'b0 && (pad1_clk !== 1'b1 || pad2_clk !== 1'b1 || pad_latch !== 1'b0))
        line_viol++;
      if (own === 1'b1 && own_prev === 1'b0) own_rise_cyc = cyc;
      if (own === 1'b0 && own_prev === 1'b1) own_fall_cyc = cyc;
      own_prev = own;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_latch"}, {31'd0, pad_latch}, 32'd0);
    chk({tag, "_clk1"}, {31'd0, pad1_clk}, 32'd1);
    chk({tag, "_clk2"}, {31'd0, pad2_clk}, 32'd1);
    chk({tag, "_own"}, {31'd0, own}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, buttons_valid}, 32'd0);
    chk({tag, "_shadows"}, {16'd0, pad1_buttons, pad2_buttons}, 32'd0);
  endtask

  // Full poll from a single request; pa/pb are active-low pad patterns.
  task automatic do_poll(input logic [7:0] pa, input logic [7:0] pb);
    int k;
    pat1     = pa;
    pat2     = pb;
    k        = cyc;
    poll_req = 1'b1;
    expect_done(~pa, ~pb, k + 103);
    tick(1);
    poll_req = 1'b0;
    tick(106);
    chk("latch_len", last_latch_len, L);
    chk("low_pulses", low_cnt, 7);
    chk("low_width_bad", width_bad, 0);
    chk("own_rise", own_rise_cyc, k + 1);
    chk("own_fall", own_fall_cyc, k + 104);
    chk("shadow1", {24'd0, pad1_buttons}, {24'd0, m_sh1});
    chk("shadow2", {24'd0, pad2_buttons}, {24'd0, m_sh2});
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k, j, viol;
    rst        = 1'b1;
    poll_req   = 1'b0;
    cpu_access = 1'b0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // Default poll: A pressed on pad 1, nothing on pad 2
    do_poll(8'hFE, 8'hFF);

    // Request deferred by CPU access held for 20 cycles
    pat1       = 8'hFE;
    pat2       = 8'hFF;
    cpu_access = 1'b1;
    poll_req   = 1'b1;
    tick(1);
    poll_req = 1'b0;
    viol     = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1 || own !== 1'b0) viol++;
      tick(1);
    end
    chk("defer_busy_own", viol, 0);
    j          = cyc;
    cpu_access = 1'b0;
    expect_done(8'h01, 8'h00, j + 103);
    tick(106);
    chk("defer_own_rise", own_rise_cyc, j + 1);
    chk("defer_pulses", low_cnt, 7);

    // Shadows to A5 (two polls so the debounced build also settles)
    do_poll(8'h5A, 8'h5A);
    do_poll(8'h5A, 8'h5A);

    // Mid-poll preemption during the 3rd clock-low (edges k+43..k+49)
    pat1     = 8'hC3;
    pat2     = 8'hC3;
    k        = cyc;
    poll_req = 1'b1;
    tick(1);
    poll_req = 1'b0;
    while (cyc < k + 45) tick(1);
    chk("pre_in_low3", {pad1_clk, 31'(low_cnt)}, {1'b0, 31'd2});
    cpu_access = 1'b1;
    tick(1);
    chk("pre_own", {31'd0, own}, 32'd0);
    chk("pre_clks", {30'd0, pad1_clk, pad2_clk}, 32'd3);
    chk("pre_latch", {31'd0, pad_latch}, 32'd0);
    chk("pre_busy", {31'd0, busy}, 32'd1);
    chk("pre_shadows", {16'd0, pad1_buttons, pad2_buttons}, 32'h0000A5A5);
    tick(4);
    j          = cyc;
    cpu_access = 1'b0;
    expect_done(8'h3C, 8'h3C, j + 103);
    tick(106);
    chk("restart_own_rise", own_rise_cyc, j + 1);
    chk("restart_pulses", low_cnt, 7);
    chk("restart_shadow1", {24'd0, pad1_buttons}, {24'd0, m_sh1});

    // Reset during the first clock-high (edges k+25..k+31)
    pat1     = 8'h00;
    pat2     = 8'h00;
    k        = cyc;
    poll_req = 1'b1;
    tick(1);
    poll_req = 1'b0;
    while (cyc < k + 27) tick(1);
    chk("rst_in_high", {30'd0, own, pad1_clk}, 32'd3);
    rst = 1'b1;
    tick(1);
    check_reset_vals("rst_mid");
    rst     = 1'b0;
    m_sh1   = 8'h00;
    m_sh2   = 8'h00;
    m_prev1 = 8'h00;
    m_prev2 = 8'h00;
    tick(120);

    // Debounce sequence: 10, 10, 30, 30 on pad 1
    do_poll(8'hEF, 8'hFF);
    do_poll(8'hEF, 8'hFF);
    do_poll(8'hCF, 8'hFF);
    do_poll(8'hCF, 8'hFF);
    chk("final_shadow1", {24'd0, pad1_buttons}, 32'h30);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    chk("sb_drain", sb.size(), 0);
    chk("line_viol", line_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
